// File: rtl/axil_regfile.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// axil_regfile
//
// AXI4-Lite slave register file. Write address and write data are captured
// in independent holding registers; once both are full the write commits
// (byte-strobed) into one of C_NUM_REGS registers and a B response is raised.
// Reads are answered on the edge of the AR handshake. Every register is
// exposed on a flat output vector, and each committed in-range write produces
// a one-cycle pulse on the matching bit of o_wr_pulse.
//
// Optional feature macro: AXIL_REGFILE_SLVERR_EN
//   defined   -> out-of-range accesses answer SLVERR (2'b10)
//   undefined -> out-of-range accesses answer OKAY (2'b00)
//   Out-of-range writes never change state; out-of-range reads return 0.
//
// Ports:
//   i_clk, i_axi_reset            clock (rising edge), async active-high reset
//   i_axi_aw* / o_axi_awready     write address channel (awprot ignored)
//   i_axi_w*  / o_axi_wready      write data channel with byte strobes
//   o_axi_bvalid/bresp, i_axi_bready   write response channel
//   i_axi_ar* / o_axi_arready     read address channel (arprot ignored)
//   o_axi_rvalid/rdata/rresp, i_axi_rready   read data channel
//   o_regs                        register k at bits [k*W +: W]
//   o_wr_pulse                    bit k high for one cycle after reg k written
// ----------------------------------------------------------------------------
module axil_regfile #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 6,
  parameter int C_NUM_REGS       = 12
) (
  input  logic                                   i_clk,
  input  logic                                   i_axi_reset,

  input  logic                                   i_axi_awvalid,
  output logic                                   o_axi_awready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]            i_axi_awaddr,
  input  logic [2:0]                             i_axi_awprot,

  input  logic                                   i_axi_wvalid,
  output logic                                   o_axi_wready,
  input  logic [C_AXI_DATA_WIDTH-1:0]            i_axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]          i_axi_wstrb,

  output logic                                   o_axi_bvalid,
  input  logic                                   i_axi_bready,
  output logic [1:0]                             o_axi_bresp,

  input  logic                                   i_axi_arvalid,
  output logic                                   o_axi_arready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]            i_axi_araddr,
  input  logic [2:0]                             i_axi_arprot,

  output logic                                   o_axi_rvalid,
  input  logic                                   i_axi_rready,
  output logic [C_AXI_DATA_WIDTH-1:0]            o_axi_rdata,
  output logic [1:0]                             o_axi_rresp,

  output logic [C_NUM_REGS*C_AXI_DATA_WIDTH-1:0] o_regs,
  output logic [C_NUM_REGS-1:0]                  o_wr_pulse
);

  localparam int NB      = C_AXI_DATA_WIDTH / 8;
  localparam int ADDRLSB = $clog2(NB);
  localparam int IDX_W   = C_AXI_ADDR_WIDTH - ADDRLSB;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

  // Readies are held low during reset and only rise on the first edge after
  // release, so they cannot be derived purely from the empty holding state.
  logic                        ready_en_q, ready_en_d;

  logic                        aw_held_q, aw_held_d;
  logic [IDX_W-1:0]            aw_idx_q, aw_idx_d;
  logic                        w_held_q, w_held_d;
  logic [C_AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [NB-1:0]               w_strb_q, w_strb_d;

  logic                        bvalid_q, bvalid_d;
  logic [1:0]                  bresp_q, bresp_d;

  logic                        rvalid_q, rvalid_d;
  logic [C_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                  rresp_q, rresp_d;

  logic [C_AXI_DATA_WIDTH-1:0] regs_q [C_NUM_REGS];
  logic [C_AXI_DATA_WIDTH-1:0] regs_d [C_NUM_REGS];
  logic [C_NUM_REGS-1:0]       wr_pulse_q, wr_pulse_d;

  logic             aw_fire;
  logic             w_fire;
  logic             ar_fire;
  logic             commit;
  logic [IDX_W-1:0] ar_idx;

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return int'(idx) < C_NUM_REGS;
  endfunction

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{i_axi_awprot, i_axi_arprot,
                           i_axi_awaddr[ADDRLSB-1:0], i_axi_araddr[ADDRLSB-1:0]};

  assign o_axi_awready = ready_en_q && !aw_held_q && !bvalid_q;
  assign o_axi_wready  = ready_en_q && !w_held_q && !bvalid_q;
  assign o_axi_arready = ready_en_q && !rvalid_q;

  assign aw_fire = i_axi_awvalid && o_axi_awready;
  assign w_fire  = i_axi_wvalid && o_axi_wready;
  assign ar_fire = i_axi_arvalid && o_axi_arready;
  assign commit  = aw_held_q && w_held_q;
  assign ar_idx  = i_axi_araddr[C_AXI_ADDR_WIDTH-1:ADDRLSB];

  assign o_axi_bvalid = bvalid_q;
  assign o_axi_bresp  = bresp_q;
  assign o_axi_rvalid = rvalid_q;
  assign o_axi_rdata  = rdata_q;
  assign o_axi_rresp  = rresp_q;
  assign o_wr_pulse   = wr_pulse_q;

  for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_flat
    assign o_regs[k*C_AXI_DATA_WIDTH +: C_AXI_DATA_WIDTH] = regs_q[k];
  end

  // Holding registers. A hold cannot fill and drain in the same cycle: a
  // commit needs it full, a handshake needs it empty.
  always_comb begin
    ready_en_d = 1'b1;
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    w_held_d   = w_held_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    if (aw_fire) begin
      aw_held_d = 1'b1;
      aw_idx_d  = i_axi_awaddr[C_AXI_ADDR_WIDTH-1:ADDRLSB];
    end
    if (w_fire) begin
      w_held_d = 1'b1;
      w_data_d = i_axi_wdata;
      w_strb_d = i_axi_wstrb;
    end
  end

  // Commit and B channel. Out-of-range writes still produce a response but
  // leave every register and the pulse vector untouched.
  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    if (bvalid_q && i_axi_bready) begin
      bvalid_d = 1'b0;
    end
    if (commit) begin
      bvalid_d = 1'b1;
      if (idx_in_range(aw_idx_q)) begin
        bresp_d = RESP_OKAY;
        for (int k = 0; k < C_NUM_REGS; k++) begin
          if (aw_idx_q == IDX_W'(k)) begin
            wr_pulse_d[k] = 1'b1;
            for (int b = 0; b < NB; b++) begin
              if (w_strb_q[b]) begin
                regs_d[k][b*8 +: 8] = w_data_q[b*8 +: 8];
              end
            end
          end
        end
      end else begin
        bresp_d = RESP_OOR;
      end
    end
  end

  // Read channel. Data comes from the current register state, so a read
  // that lands on the same edge as a commit sees the pre-write value.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && i_axi_rready) begin
      rvalid_d = 1'b0;
    end
    if (ar_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_OOR;
      if (idx_in_range(ar_idx)) begin
        rresp_d = RESP_OKAY;
        for (int k = 0; k < C_NUM_REGS; k++) begin
          if (ar_idx == IDX_W'(k)) begin
            rdata_d = regs_q[k];
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_axi_reset) begin
    if (i_axi_reset) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      wr_pulse_q <= '0;
      for (int k = 0; k < C_NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      ready_en_q <= ready_en_d;
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

endmodule

// File: tb/tb_axil_regfile.sv
`timescale 1ns/1ps
// Self-checking bench for axil_regfile: directed scenarios plus a randomized
// read/write mix checked against an array model of the register file.
module tb_axil_regfile;

  localparam int W   = 32;
  localparam int AWD = 6;
  localparam int N   = 12;

`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           awvalid, awready, wvalid, wready, bvalid, bready;
  logic           arvalid, arready, rvalid, rready;
  logic [AWD-1:0] awaddr, araddr;
  logic [2:0]     awprot, arprot;
  logic [W-1:0]   wdata, rdata;
  logic [W/8-1:0] wstrb;
  logic [1:0]     bresp, rresp;
  logic [N*W-1:0] regs;
  logic [N-1:0]   wr_pulse;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] model [N];

  always #5 clk = ~clk;

  axil_regfile #(
    .C_AXI_DATA_WIDTH(W),
    .C_AXI_ADDR_WIDTH(AWD),
    .C_NUM_REGS(N)
  ) dut (
    .i_clk(clk), .i_axi_reset(rst),
    .i_axi_awvalid(awvalid), .o_axi_awready(awready),
    .i_axi_awaddr(awaddr), .i_axi_awprot(awprot),
    .i_axi_wvalid(wvalid), .o_axi_wready(wready),
    .i_axi_wdata(wdata), .i_axi_wstrb(wstrb),
    .o_axi_bvalid(bvalid), .i_axi_bready(bready), .o_axi_bresp(bresp),
    .i_axi_arvalid(arvalid), .o_axi_arready(arready),
    .i_axi_araddr(araddr), .i_axi_arprot(arprot),
    .o_axi_rvalid(rvalid), .i_axi_rready(rready),
    .o_axi_rdata(rdata), .o_axi_rresp(rresp),
    .o_regs(regs), .o_wr_pulse(wr_pulse)
  );

  // ---- reference model ----------------------------------------------------
  function automatic void model_reset();
    for (int k = 0; k < N; k++) model[k] = '0;
  endfunction

  function automatic void model_write(input int idx, input logic [W-1:0] d,
                                      input logic [W/8-1:0] s);
    if (idx < N) begin
      for (int b = 0; b < W/8; b++) begin
        if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
      end
    end
  endfunction

  function automatic logic [W-1:0] model_read(input int idx);
    return (idx < N) ? model[idx] : '0;
  endfunction

  function automatic logic [N*W-1:0] model_flat();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = model[k];
    return v;
  endfunction

  // ---- drivers ------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [AWD-1:0] addr, input logic [W-1:0] d,
                           input logic [W/8-1:0] s, output logic [1:0] resp,
                           output logic [N-1:0] pulse, output logic ok);
    int   cnt;
    logic af, wf;
    ok = 1'b1; resp = '0; pulse = '0;
    awaddr = addr; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    cnt = 0;
    while ((awvalid || wvalid) && cnt < 20) begin
      af = awvalid && awready;
      wf = wvalid && wready;
      tick();
      if (af) awvalid = 1'b0;
      if (wf) wvalid = 1'b0;
      cnt++;
    end
    if (awvalid || wvalid) begin
      awvalid = 1'b0; wvalid = 1'b0; ok = 1'b0;
      return;
    end
    cnt = 0;
    while (!bvalid && cnt < 20) begin tick(); cnt++; end
    if (!bvalid) begin ok = 1'b0; return; end
    resp = bresp; pulse = wr_pulse;
    bready = 1'b1; tick(); bready = 1'b0;
  endtask

  task automatic axi_read(input logic [AWD-1:0] addr, output logic [W-1:0] d,
                          output logic [1:0] resp, output logic ok);
    int   cnt;
    logic fire;
    ok = 1'b1; d = '0; resp = '0;
    araddr = addr; arvalid = 1'b1;
    cnt = 0;
    while (arvalid && cnt < 20) begin
      fire = arready;
      tick();
      if (fire) arvalid = 1'b0;
      cnt++;
    end
    if (arvalid) begin arvalid = 1'b0; ok = 1'b0; return; end
    cnt = 0;
    while (!rvalid && cnt < 20) begin tick(); cnt++; end
    if (!rvalid) begin ok = 1'b0; return; end
    d = rdata; resp = rresp;
    rready = 1'b1; tick(); rready = 1'b0;
  endtask

  // ---- scenarios ----------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    repeat (3) tick();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_handshake: actual=%b expected=00000",
               {awready, wready, arready, bvalid, rvalid});
    end
    checks++;
    if (regs !== '0 || wr_pulse !== '0) begin
      failures++;
      $display("[TB] FAIL reset_regs: actual regs=%h pulse=%h expected 0", regs, wr_pulse);
    end
    checks++;
    if ({bresp, rresp, rdata} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_resp: actual bresp=%b rresp=%b rdata=%h expected 0",
               bresp, rresp, rdata);
    end
    rst = 1'b0;
    #2;
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL ready_before_edge: actual=%b expected=000", {awready, wready, arready});
    end
    tick();
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      failures++;
      $display("[TB] FAIL ready_after_edge: actual=%b expected=111", {awready, wready, arready});
    end
    model_reset();
  endtask

  task automatic test_same_cycle_write();
    awaddr = 6'h04; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bvalid_early: actual=%b expected=0", bvalid);
    end
    tick();
    model_write(1, 32'hDEADBEEF, 4'hF);
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      failures++;
      $display("[TB] FAIL same_cycle_b: actual bvalid=%b bresp=%b expected 1/00", bvalid, bresp);
    end
    checks++;
    if (regs[63:32] !== model[1] || wr_pulse !== 12'h002) begin
      failures++;
      $display("[TB] FAIL same_cycle_commit: actual reg1=%h pulse=%h expected %h/002",
               regs[63:32], wr_pulse, model[1]);
    end
    bready = 1'b1; tick(); bready = 1'b0;
    checks++;
    if (wr_pulse !== '0 || bvalid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pulse_one_cycle: actual pulse=%h bvalid=%b expected 0/0", wr_pulse, bvalid);
    end
  endtask

  task automatic test_w_before_aw();
    wdata = 32'h000000AA; wstrb = 4'h1; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL wready_after_w_%0d: actual=%b expected=0", i, wready);
      end
      tick();
    end
    awaddr = 6'h04; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    tick();
    model_write(1, 32'h000000AA, 4'h1);
    checks++;
    if (bvalid !== 1'b1 || wready !== 1'b0 || regs[63:32] !== model[1]) begin
      failures++;
      $display("[TB] FAIL w_first_commit: actual bvalid=%b wready=%b reg1=%h expected 1/0/%h",
               bvalid, wready, regs[63:32], model[1]);
    end
    bready = 1'b1; tick(); bready = 1'b0;
    checks++;
    if (wready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wready_after_b: actual=%b expected=1", wready);
    end
  endtask

  task automatic test_read_backpressure();
    logic [W-1:0] exp_d;
    exp_d = model_read(1);
    araddr = 6'h04; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== exp_d || rresp !== 2'b00 || arready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL read_hold_%0d: actual rvalid=%b rdata=%h rresp=%b arready=%b expected 1/%h/00/0",
                 i, rvalid, rdata, rresp, arready, exp_d);
      end
      tick();
    end
    rready = 1'b1; tick(); rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL read_release: actual rvalid=%b arready=%b expected 0/1", rvalid, arready);
    end
  endtask

  task automatic test_boundary();
    logic [W-1:0]  d, rd;
    logic [1:0]    resp;
    logic [N-1:0]  pulse;
    logic          ok;
    d = $urandom;
    axi_write(6'h2C, d, 4'hF, resp, pulse, ok);
    model_write(11, d, 4'hF);
    checks++;
    if (!ok || resp !== 2'b00 || pulse !== 12'h800 || regs !== model_flat()) begin
      failures++;
      $display("[TB] FAIL last_reg_write: actual ok=%b bresp=%b pulse=%h reg11=%h expected 1/00/800/%h",
               ok, resp, pulse, regs[11*W +: W], model[11]);
    end
    axi_read(6'h2C, rd, resp, ok);
    checks++;
    if (!ok || rd !== model_read(11) || resp !== 2'b00) begin
      failures++;
      $display("[TB] FAIL last_reg_read: actual ok=%b rdata=%h rresp=%b expected 1/%h/00",
               ok, rd, resp, model_read(11));
    end
    axi_write(6'h30, $urandom, 4'hF, resp, pulse, ok);
    checks++;
    if (!ok || resp !== OOR || pulse !== '0 || regs !== model_flat()) begin
      failures++;
      $display("[TB] FAIL oor_write: actual ok=%b bresp=%b pulse=%h expected 1/%b/000 regs unchanged",
               ok, resp, pulse, OOR);
    end
    axi_read(6'h30, rd, resp, ok);
    checks++;
    if (!ok || rd !== '0 || resp !== OOR) begin
      failures++;
      $display("[TB] FAIL oor_read: actual ok=%b rdata=%h rresp=%b expected 1/0/%b", ok, rd, resp, OOR);
    end
  endtask

  task automatic test_read_vs_commit();
    logic [W-1:0] old_d, new_d;
    old_d = model_read(3);
    new_d = $urandom;
    awaddr = 6'h0C; wdata = new_d; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 6'h0C; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    model_write(3, new_d, 4'hF);
    checks++;
    if (rvalid !== 1'b1 || rdata !== old_d || bvalid !== 1'b1 || regs[3*W +: W] !== model[3]) begin
      failures++;
      $display("[TB] FAIL read_vs_commit: actual rvalid=%b rdata=%h bvalid=%b reg3=%h expected 1/%h/1/%h",
               rvalid, rdata, bvalid, regs[3*W +: W], old_d, model[3]);
    end
    bready = 1'b1; rready = 1'b1; tick(); bready = 1'b0; rready = 1'b0;
  endtask

  task automatic test_reset_mid();
    awaddr = 6'h04; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wdata = $urandom; wstrb = 4'hF; wvalid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || wr_pulse !== '0 || regs !== '0) begin
      failures++;
      $display("[TB] FAIL reset_async: actual hs=%b pulse=%h regs=%h expected all 0",
               {awready, wready, arready, bvalid, rvalid}, wr_pulse, regs);
    end
    wvalid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (regs[63:32] !== model[1] || bvalid !== 1'b0 || wr_pulse !== '0 || awready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_no_partial: actual reg1=%h bvalid=%b pulse=%h awready=%b expected 0/0/0/1",
               regs[63:32], bvalid, wr_pulse, awready);
    end
  endtask

  task automatic test_bready_stall();
    logic [W-1:0] d1, d2;
    int           idx;
    idx = $urandom_range(0, N-1);
    d1 = $urandom; d2 = $urandom;
    awaddr = AWD'(idx * 4); wdata = d1; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    model_write(idx, d1, 4'hF);
    awaddr = 6'h08; awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL b_stall_%0d: actual bvalid=%b bresp=%b awready=%b wready=%b expected 1/00/0/0",
                 i, bvalid, bresp, awready, wready);
      end
      tick();
    end
    bready = 1'b1;
    checks++;
    if (awready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL aw_block_on_bready: actual=%b expected=0", awready);
    end
    tick();
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL aw_after_b: actual bvalid=%b awready=%b expected 0/1", bvalid, awready);
    end
    tick();
    awvalid = 1'b0;
    wdata = d2; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick();
    model_write(2, d2, 4'hF);
    checks++;
    if (bvalid !== 1'b1 || wr_pulse !== 12'h004 || regs !== model_flat()) begin
      failures++;
      $display("[TB] FAIL second_write: actual bvalid=%b pulse=%h reg2=%h expected 1/004/%h",
               bvalid, wr_pulse, regs[2*W +: W], model[2]);
    end
    bready = 1'b1; tick(); bready = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0]     idx;
    logic [1:0]     lo;
    logic [W-1:0]   d, rd;
    logic [W/8-1:0] s;
    logic [1:0]     resp, exp_resp;
    logic [N-1:0]   pulse, exp_pulse;
    logic           ok;
    for (int i = 0; i < 60; i++) begin
      idx = 4'($urandom_range(0, 15));
      lo  = 2'($urandom);
      exp_resp = (int'(idx) < N) ? 2'b00 : OOR;
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom; s = 4'($urandom);
        axi_write({idx, lo}, d, s, resp, pulse, ok);
        model_write(int'(idx), d, s);
        exp_pulse = (int'(idx) < N) ? N'(1) << idx : '0;
        checks++;
        if (!ok || resp !== exp_resp || pulse !== exp_pulse || regs !== model_flat()) begin
          failures++;
          $display("[TB] FAIL rand_write_%0d: idx=%0d actual ok=%b bresp=%b pulse=%h expected 1/%b/%h",
                   i, idx, ok, resp, pulse, exp_resp, exp_pulse);
        end
      end else begin
        axi_read({idx, lo}, rd, resp, ok);
        checks++;
        if (!ok || rd !== model_read(int'(idx)) || resp !== exp_resp) begin
          failures++;
          $display("[TB] FAIL rand_read_%0d: idx=%0d actual ok=%b rdata=%h rresp=%b expected 1/%h/%b",
                   i, idx, ok, rd, resp, model_read(int'(idx)), exp_resp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle_write();
    test_w_before_aw();
    test_read_backpressure();
    test_boundary();
    test_read_vs_commit();
    test_reset_mid();
    test_bready_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
